// File: rtl/game_state_manager.sv
// Frame-committed game state: gift count, score, lives and the game phase FSM.
// Per-pixel event strobes are latched into sticky flags and acted on once per startOfFrame.
module game_state_manager #(
    parameter int NUM_GIFTS   = 4,
    parameter int LIVES       = 3,
    parameter int GIFT_POINTS = 10,
    parameter int WIN_POINTS  = 100,
    parameter int HOLD_FRAMES = 90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        startGame,
    input  logic        Remove_Gift,
    input  logic        victory,
    input  logic        Loss,
    output logic        gift_clear,
    output logic [3:0]  giftsRemaining,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [2:0]  gameState,
    output logic        freezeMotion,
    output logic        restartLevel
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_PLAY      = 3'b001,
        ST_LEVEL_WON = 3'b010,
        ST_LIFE_LOST = 3'b011,
        ST_GAME_OVER = 3'b100
    } state_e;

    localparam logic [3:0]  GIFTS_INIT = 4'(NUM_GIFTS);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [15:0] GIFT_ADD   = 16'(GIFT_POINTS);
    localparam logic [15:0] WIN_ADD    = 16'(WIN_POINTS);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);

    state_e      state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [3:0]  gifts_q, gifts_d;
    logic        gift_clear_q, gift_clear_d;
    logic        freeze_q, freeze_d;
    logic        restart_q, restart_d;
    logic [7:0]  hold_q, hold_d;
    logic        got_gift_q, got_gift_d;
    logic        got_hole_q, got_hole_d;
    logic        got_loss_q, got_loss_d;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        lives_d    = lives_q;
        gifts_d    = gifts_q;
        hold_d     = hold_q;
        restart_d  = 1'b0;
        got_gift_d = got_gift_q;
        got_hole_d = got_hole_q;
        got_loss_d = got_loss_q;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                got_gift_d = 1'b0;
                got_hole_d = 1'b0;
                got_loss_d = 1'b0;
                if (startGame) begin
                    score_d   = 16'd0;
                    lives_d   = LIVES_INIT;
                    gifts_d   = GIFTS_INIT;
                    hold_d    = 8'd0;
                    restart_d = 1'b1;
                    state_d   = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (startOfFrame) begin
                    // Priority loss > hole > gift; a hole without all gifts collected falls through to gift.
                    if (got_loss_q) begin
                        lives_d = lives_q - 2'd1;
                        hold_d  = 8'd0;
                        state_d = (lives_q == 2'd1) ? ST_GAME_OVER : ST_LIFE_LOST;
                    end else if (got_hole_q && gift_clear_q) begin
                        score_d = sat_add(score_q, WIN_ADD);
                        hold_d  = 8'd0;
                        state_d = ST_LEVEL_WON;
                    end else if (got_gift_q && (gifts_q != 4'd0)) begin
                        gifts_d = gifts_q - 4'd1;
                        score_d = sat_add(score_q, GIFT_ADD);
                    end
                    // Inputs on the commit cycle belong to the next frame.
                    got_gift_d = Remove_Gift;
                    got_hole_d = victory;
                    got_loss_d = Loss;
                end else begin
                    got_gift_d = got_gift_q | Remove_Gift;
                    got_hole_d = got_hole_q | victory;
                    got_loss_d = got_loss_q | Loss;
                end
                if (state_d != ST_PLAY) begin
                    got_gift_d = 1'b0;
                    got_hole_d = 1'b0;
                    got_loss_d = 1'b0;
                end
            end

            ST_LEVEL_WON, ST_LIFE_LOST: begin
                got_gift_d = 1'b0;
                got_hole_d = 1'b0;
                got_loss_d = 1'b0;
                if (startOfFrame) begin
                    if (hold_q == HOLD_LAST) begin
                        restart_d = 1'b1;
                        hold_d    = 8'd0;
                        state_d   = ST_PLAY;
                        if (state_q == ST_LEVEL_WON) begin
                            gifts_d = GIFTS_INIT;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end

            default: begin
                got_gift_d = 1'b0;
                got_hole_d = 1'b0;
                got_loss_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        gift_clear_d = (gifts_d == 4'd0);
        freeze_d     = (state_d != ST_PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            score_q      <= 16'd0;
            lives_q      <= LIVES_INIT;
            gifts_q      <= GIFTS_INIT;
            gift_clear_q <= 1'b0;
            freeze_q     <= 1'b1;
            restart_q    <= 1'b0;
            hold_q       <= 8'd0;
            got_gift_q   <= 1'b0;
            got_hole_q   <= 1'b0;
            got_loss_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            gifts_q      <= gifts_d;
            gift_clear_q <= gift_clear_d;
            freeze_q     <= freeze_d;
            restart_q    <= restart_d;
            hold_q       <= hold_d;
            got_gift_q   <= got_gift_d;
            got_hole_q   <= got_hole_d;
            got_loss_q   <= got_loss_d;
        end
    end

    assign gameState      = state_q;
    assign score          = score_q;
    assign lives          = lives_q;
    assign giftsRemaining = gifts_q;
    assign gift_clear     = gift_clear_q;
    assign freezeMotion   = freeze_q;
    assign restartLevel   = restart_q;

endmodule

// File: tb/tb_game_state_manager.sv
// Bench for game_state_manager: directed game scenario with literal expectations,
// then randomized play, all checked every cycle against a frame-level game model.
module tb_game_state_manager;

    localparam int P_GIFTS    = 4;
    localparam int P_LIVES    = 3;
    localparam int P_GIFT_A   = 10;
    localparam int P_GIFT_B   = 65528;
    localparam int P_WIN      = 100;
    localparam int P_HOLD     = 90;

    localparam int S_IDLE = 0, S_PLAY = 1, S_WON = 2, S_LOST = 3, S_OVER = 4;

    logic clk = 1'b0;
    logic reset = 1'b1, sof = 1'b0, start = 1'b0, rg = 1'b0, vic = 1'b0, loss = 1'b0;

    logic        a_clear, a_freeze, a_restart;
    logic [3:0]  a_gifts;
    logic [15:0] a_score;
    logic [1:0]  a_lives;
    logic [2:0]  a_state;

    logic        b_clear, b_freeze, b_restart;
    logic [3:0]  b_gifts;
    logic [15:0] b_score;
    logic [1:0]  b_lives;
    logic [2:0]  b_state;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    // Frame-level game model (expected registered outputs after each edge).
    int m_state   = S_IDLE;
    int m_score_a = 0;
    int m_score_b = 0;
    int m_lives   = P_LIVES;
    int m_gifts   = P_GIFTS;
    int m_hold    = 0;
    int m_restart = 0;
    bit m_gg = 1'b0, m_gh = 1'b0, m_gl = 1'b0;

    always #5 clk = ~clk;

    game_state_manager #(
        .NUM_GIFTS(P_GIFTS), .LIVES(P_LIVES), .GIFT_POINTS(P_GIFT_A),
        .WIN_POINTS(P_WIN), .HOLD_FRAMES(P_HOLD)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(sof), .startGame(start),
        .Remove_Gift(rg), .victory(vic), .Loss(loss),
        .gift_clear(a_clear), .giftsRemaining(a_gifts), .score(a_score),
        .lives(a_lives), .gameState(a_state), .freezeMotion(a_freeze),
        .restartLevel(a_restart)
    );

    // Same game, huge gift value: drives the score into saturation.
    game_state_manager #(
        .NUM_GIFTS(P_GIFTS), .LIVES(P_LIVES), .GIFT_POINTS(P_GIFT_B),
        .WIN_POINTS(P_WIN), .HOLD_FRAMES(P_HOLD)
    ) dut_sat (
        .clk(clk), .reset(reset), .startOfFrame(sof), .startGame(start),
        .Remove_Gift(rg), .victory(vic), .Loss(loss),
        .gift_clear(b_clear), .giftsRemaining(b_gifts), .score(b_score),
        .lives(b_lives), .gameState(b_state), .freezeMotion(b_freeze),
        .restartLevel(b_restart)
    );

    function automatic int sat16(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_restart = 0;
        if (reset) begin
            m_state = S_IDLE; m_score_a = 0; m_score_b = 0;
            m_lives = P_LIVES; m_gifts = P_GIFTS; m_hold = 0;
            m_gg = 0; m_gh = 0; m_gl = 0;
        end else if (m_state == S_IDLE || m_state == S_OVER) begin
            m_gg = 0; m_gh = 0; m_gl = 0;
            if (start) begin
                m_score_a = 0; m_score_b = 0;
                m_lives = P_LIVES; m_gifts = P_GIFTS;
                m_restart = 1; m_state = S_PLAY; m_hold = 0;
            end
        end else if (m_state == S_PLAY) begin
            if (sof) begin
                if (m_gl) begin
                    m_lives = m_lives - 1;
                    m_state = (m_lives == 0) ? S_OVER : S_LOST;
                    m_hold = 0;
                end else if (m_gh && m_gifts == 0) begin
                    m_score_a = sat16(m_score_a + P_WIN);
                    m_score_b = sat16(m_score_b + P_WIN);
                    m_state = S_WON;
                    m_hold = 0;
                end else if (m_gg && m_gifts > 0) begin
                    m_gifts = m_gifts - 1;
                    m_score_a = sat16(m_score_a + P_GIFT_A);
                    m_score_b = sat16(m_score_b + P_GIFT_B);
                end
                m_gg = rg; m_gh = vic; m_gl = loss;
            end else begin
                m_gg = m_gg | rg; m_gh = m_gh | vic; m_gl = m_gl | loss;
            end
            if (m_state != S_PLAY) begin
                m_gg = 0; m_gh = 0; m_gl = 0;
            end
        end else begin
            m_gg = 0; m_gh = 0; m_gl = 0;
            if (sof) begin
                if (m_hold == P_HOLD - 1) begin
                    m_restart = 1;
                    if (m_state == S_WON) m_gifts = P_GIFTS;
                    m_state = S_PLAY;
                    m_hold = 0;
                end else begin
                    m_hold = m_hold + 1;
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (cmp_en) begin
            check("state",      a_state,   m_state);
            check("score",      a_score,   m_score_a);
            check("lives",      a_lives,   m_lives);
            check("gifts",      a_gifts,   m_gifts);
            check("gift_clear", a_clear,   (m_gifts == 0) ? 1 : 0);
            check("freeze",     a_freeze,  (m_state != S_PLAY) ? 1 : 0);
            check("restart",    a_restart, m_restart);
            check("sat_score",  b_score,   m_score_b);
            check("sat_state",  b_state,   m_state);
        end
    end

    // One clock of stimulus; outputs are settled when the task returns.
    task automatic cyc(input bit r, input bit s, input bit st, input bit g, input bit v, input bit l);
        @(negedge clk);
        reset = r; sof = s; start = st; rg = g; vic = v; loss = l;
        @(posedge clk);
        #1;
        reset = 0; sof = 0; start = 0; rg = 0; vic = 0; loss = 0;
    endtask

    task automatic gift_frame();
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
    endtask

    task automatic hold_out();
        for (int i = 0; i < P_HOLD; i++) begin
            cyc(0, 0, 0, 1, 1, 1);
            cyc(0, 1, 0, 0, 0, 0);
        end
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        cmp_en = 1'b1;
        check("rst_state", a_state, 0);
        check("rst_score", a_score, 0);
        check("rst_lives", a_lives, 3);
        check("rst_gifts", a_gifts, 4);
        check("rst_clear", a_clear, 0);
        check("rst_freeze", a_freeze, 1);
        check("rst_restart", a_restart, 0);

        cyc(0, 0, 1, 0, 0, 0);
        check("start_state", a_state, 1);
        check("start_restart", a_restart, 1);
        check("start_freeze", a_freeze, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("start_restart_drop", a_restart, 0);

        for (int i = 0; i < 200; i++) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("gift1_gifts", a_gifts, 3);
        check("gift1_score", a_score, 10);
        check("sat_first", b_score, 16'hFFF8);
        cyc(0, 1, 0, 0, 0, 0);
        check("gift_once", a_gifts, 3);
        cyc(0, 1, 0, 1, 0, 0);
        check("coincident_not_now", a_gifts, 3);
        cyc(0, 1, 0, 0, 0, 0);
        check("coincident_next", a_gifts, 2);
        check("coincident_score", a_score, 20);
        check("sat_clamp", b_score, 16'hFFFF);

        gift_frame();
        gift_frame();
        check("all_gifts", a_gifts, 0);
        check("all_clear", a_clear, 1);
        check("all_score", a_score, 40);
        gift_frame();
        check("gift_at_zero", a_score, 40);

        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("won_state", a_state, 2);
        check("won_score", a_score, 140);
        for (int i = 0; i < P_HOLD - 1; i++) begin
            cyc(0, 0, 0, 1, 1, 1);
            cyc(0, 1, 0, 0, 0, 0);
        end
        check("won_hold", a_state, 2);
        cyc(0, 1, 0, 0, 0, 0);
        check("won_restart", a_restart, 1);
        check("won_back", a_state, 1);
        check("won_reload", a_gifts, 4);

        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("hole_no_clear", a_state, 1);
        check("hole_no_score", a_score, 140);

        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        check("loss1_lives", a_lives, 2);
        check("loss1_state", a_state, 3);
        check("loss1_gifts", a_gifts, 4);
        hold_out();
        check("lost_back", a_state, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        hold_out();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        check("over_lives", a_lives, 0);
        check("over_state", a_state, 4);

        cyc(0, 1, 1, 0, 0, 0);
        check("restart_state", a_state, 1);
        check("restart_score", a_score, 0);
        check("restart_lives", a_lives, 3);

        for (int i = 0; i < 4; i++) gift_frame();
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 1, 1);
        check("midhold_state", a_state, 0);
        check("midhold_score", a_score, 0);
        check("midhold_gifts", a_gifts, 4);
        check("midhold_restart", a_restart, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("midhold_restart2", a_restart, 0);

        for (int i = 0; i < 20000; i++) begin
            bit r, s, st;
            r  = ($urandom_range(0, 3999) == 0);
            s  = ($urandom_range(0, 3) == 0);
            st = (m_state == S_IDLE || m_state == S_OVER) ?
                 ($urandom_range(0, 9) == 0) : ($urandom_range(0, 49) == 0);
            cyc(r, s, st, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 39) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
